// File: rtl/cdc_req_ack_sender.sv
// Purpose    : source half of a four-phase req/ack crossing; holds each accepted word on o_data while o_req is high.
// Latency    : accepted word and o_req appear one edge after acceptance; next accept is 2*SYNC_STAGES+3 cycles later at best.
// Backpressure: o_ready drops for the whole handshake and while the synchronised ack is still high.
//
// Ports:
//   i_clk, i_rst            local clock, asynchronous active-high reset
//   i_valid/o_ready/i_data  upstream word interface (valid/ready)
//   o_req/o_data            registered request and word towards the far domain
//   i_ack                   asynchronous acknowledge from the far domain
//   o_busy                  a handshake is in progress
//   o_err/i_err_clr         sticky handshake-timeout flag and its clear
//
// Optional feature: define CDC_SENDER_TIMEOUT_EN to bound each handshake phase
// to TIMEOUT cycles. Without it o_err is constant 0, i_err_clr is ignored and
// the sender waits for the far side indefinitely.

module cdc_req_ack_sender #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_req,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ack,
   output logic             o_busy,
   output logic             o_err,
   input  logic             i_err_clr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      ACK_LO = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   req_q, req_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   logic                   ready;

   // i_ack is asynchronous: only the last synchroniser stage is ever looked at.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_ack};
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   // A still-high ack in IDLE (stale from a reset mid-handshake, or spurious)
   // blocks acceptance until the far side has returned to zero.
   assign ready = (state_q == IDLE) && !ack_s;

`ifdef CDC_SENDER_TIMEOUT_EN
   localparam int           CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          timeout_hit;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
`ifdef CDC_SENDER_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (i_valid && ready) begin
               data_d  = i_data;
               req_d   = 1'b1;
               state_d = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ACK_LO;
            end
`ifdef CDC_SENDER_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               // Far side never answered: withdraw the request and drop the word.
               req_d       = 1'b0;
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end
`endif
         end
         ACK_LO: begin
            if (!ack_s) begin
               state_d = IDLE;
            end
`ifdef CDC_SENDER_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               // Ack stuck high: give up; the IDLE ready gate still waits for it to fall.
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end
`endif
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

`ifdef CDC_SENDER_TIMEOUT_EN
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && state_q != IDLE) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Set has priority over clear so a timeout is never lost.
   always_comb begin
      err_d = err_q;
      if (timeout_hit) begin
         err_d = 1'b1;
      end else if (i_err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`else
   logic        unused_err_clr;
   logic [31:0] unused_timeout;

   assign unused_err_clr = i_err_clr;
   assign unused_timeout = TIMEOUT;
   assign o_err          = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
      end
   end

   assign o_ready = ready;
   assign o_req   = req_q;
   assign o_data  = data_q;
   assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_req_ack_sender.sv
module tb_cdc_req_ack_sender;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ack_man = 1'b0;
   logic       follow = 1'b0;
   logic       err_clr = 1'b0;
   logic       ack;
   logic       ready, req, busy, err;
   logic [7:0] odata;

   int n_cmp = 0;
   int n_bad = 0;

   // follow=1 models a zero-delay far-side responder (ack mirrors req).
   assign ack = follow ? req : ack_man;

   always #5 clk = ~clk;

   cdc_req_ack_sender #(
      .WIDTH      (8),
      .SYNC_STAGES(2),
      .TIMEOUT    (10)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid),
      .o_ready  (ready),
      .i_data   (data),
      .o_req    (req),
      .o_data   (odata),
      .i_ack    (ack),
      .o_busy   (busy),
      .o_err    (err),
      .i_err_clr(err_clr)
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       a;
      logic       e_rdy;
      logic       e_req;
      logic [7:0] e_dat;
      logic       e_busy;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset with random inputs, check outputs while reset is asserted, release mid-cycle.
   task automatic do_reset(input logic ack_after);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      valid   = 1'($urandom);
      data    = 8'($urandom);
      ack_man = 1'($urandom);
      err_clr = 1'b0;
      follow  = 1'b0;
      #2;
      chk("rst_req",   req,   0);
      chk("rst_data",  odata, 0);
      chk("rst_ready", ready, 1);
      chk("rst_busy",  busy,  0);
      chk("rst_err",   err,   0);
      tick();
      tick();
      valid   = 1'b0;
      data    = 8'h00;
      ack_man = ack_after;
      rst     = 1'b0;
   endtask

   initial begin
      logic [7:0] w [3];
      int         t [3];
      int         idx, cyc, rises, bad;
      logic       acc, prev_req;

      // Single word 0xA5; ack raised 3 cycles after req, dropped 3 cycles after req falls.
      tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
      tbl[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
      tbl[4]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
      tbl[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};

      do_reset(1'b0);
      #1;
      chk("idle_ready", ready, 1);
      chk("idle_busy",  busy,  0);
      for (int i = 0; i < 11; i++) begin
         valid   = tbl[i].v;
         data    = tbl[i].d;
         ack_man = tbl[i].a;
         tick();
         chk($sformatf("vec%0d_ready", i), ready, tbl[i].e_rdy);
         chk($sformatf("vec%0d_req",   i), req,   tbl[i].e_req);
         chk($sformatf("vec%0d_data",  i), odata, tbl[i].e_dat);
         chk($sformatf("vec%0d_busy",  i), busy,  tbl[i].e_busy);
         chk($sformatf("vec%0d_err",   i), err,   0);
      end
      valid = 1'b0;

      // Back-to-back words with valid held and a zero-delay responder.
      w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
      follow = 1'b1;
      valid  = 1'b1;
      data   = w[0];
      idx = 0; cyc = 0; rises = 0;
      for (int c = 0; c < 200; c++) begin
         if (idx >= 3 && c >= 60) break;
         acc      = valid && ready;
         prev_req = req;
         tick();
         cyc++;
         if (!prev_req && req) rises++;
         if (acc) begin
            if (idx < 3) begin
               chk($sformatf("b2b_data%0d", idx), odata, w[idx]);
               chk($sformatf("b2b_req%0d",  idx), req,   1);
               t[idx] = cyc;
            end
            idx++;
            if (idx < 3) data = w[idx];
            else valid = 1'b0;
         end
      end
      valid = 1'b0;
      chk("b2b_accepts",  idx, 3);
      chk("b2b_rises",    rises, 3);
      chk("b2b_gap01",    t[1] - t[0], 7);
      chk("b2b_gap12",    t[2] - t[1], 7);
      chk("b2b_idle",     busy, 0);
      follow = 1'b0;

      // Ack held high from reset release: nothing accepted until ack_s falls.
      do_reset(1'b1);
      tick(); tick(); tick();
      valid = 1'b1;
      data  = 8'h42;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("stale_ready%0d", i), ready, 0);
         chk($sformatf("stale_req%0d",   i), req,   0);
      end
      ack_man = 1'b0;
      tick();
      chk("stale_fall_k_ready", ready, 0);
      tick();
      chk("stale_fall_k1_ready", ready, 1);
      chk("stale_fall_k1_req",   req,   0);
      tick();
      valid = 1'b0;
      chk("stale_accept_req",  req,   1);
      chk("stale_accept_data", odata, 8'h42);
      follow = 1'b1;
      bad = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (!busy) begin bad = 0; break; end
      end
      chk("stale_drain_timeout", bad, 0);
      follow = 1'b0;

      // Responder never acks.
      do_reset(1'b0);
      valid = 1'b1;
      data  = 8'h99;
      tick();
      valid = 1'b0;
      chk("noack_req_start", req, 1);
`ifdef CDC_SENDER_TIMEOUT_EN
      bad = 0;
      for (int i = 1; i < 10; i++) begin
         tick();
         if (req !== 1'b1 || err !== 1'b0) bad++;
      end
      chk("to_hold_before_limit", bad, 0);
      tick();
      chk("to_req_dropped", req,  0);
      chk("to_err_set",     err,  1);
      chk("to_busy",        busy, 0);
      tick();
      chk("to_err_sticky", err, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_err_cleared", err, 0);
`else
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (req !== 1'b1 || err !== 1'b0 || odata !== 8'h99) bad++;
      end
      chk("noack_req_held_1000", bad, 0);
      chk("noack_busy", busy, 1);
`endif

      // Reset pulsed in REQ_HI while ack is high.
      do_reset(1'b0);
      valid = 1'b1;
      data  = 8'h5A;
      tick();
      valid = 1'b0;
      chk("mid_req_up", req, 1);
      ack_man = 1'b1;
      tick();
      chk("mid_req_still_up", req, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req_async",  req,   0);
      chk("mid_rst_busy_async", busy,  0);
      chk("mid_rst_data_async", odata, 0);
      #2;
      rst = 1'b0;
      tick(); tick(); tick();
      chk("mid_after_ready", ready, 0);
      valid   = 1'b1;
      data    = 8'h77;
      ack_man = 1'b0;
      tick();
      chk("mid_ackfall_ready0", ready, 0);
      tick();
      chk("mid_ackfall_ready1", ready, 1);
      tick();
      valid = 1'b0;
      chk("mid_next_req",  req,   1);
      chk("mid_next_data", odata, 8'h77);
      chk("mid_next_busy", busy,  1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
